// File: rtl/led_pkg.sv
// Shared types and helpers for the LED breathing display.
// FSM state encoding and bar-graph thresholds.
package led_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RISE,
        ST_HOLD_HI,
        ST_FALL,
        ST_HOLD_LO
    } state_t;

    // Bar-graph segment threshold (seg 1..4) for a given level width
    function automatic int bar_thresh(input int bits, input int seg);
        if (seg == 1)
            return 1;
        else if (seg == 2)
            return 1 << (bits - 2);
        else if (seg == 3)
            return 1 << (bits - 1);
        else
            return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/led_breather_pwm_gen.sv
// PWM generator: free-running counter, duty shadow and LED compare.
// Duty only follows level at period end so a period is never cut short.
module pwm_gen #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic [BITS-1:0] level,
    output logic            led
);

    localparam logic [BITS-1:0] MAX = '1;

    logic [BITS-1:0] pwm_cnt;
    logic [BITS-1:0] duty;

    // Free-running counter, wraps MAX -> 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + BITS'(1);
    end

    // Shadow latch at period boundary; clear bypasses the boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            duty <= '0;
        else if (clear)
            duty <= '0;
        else if (pwm_cnt == MAX)
            duty <= level;
    end

    // Registered compare; full duty stays solidly on
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            led <= 1'b0;
        else
            led <= (duty == MAX) | (pwm_cnt < duty);
    end

endmodule

// File: rtl/led_breather.sv
// Breathing LED driver: fades LED5 via PWM, bar graph on LED1-LED4.
// Brightness steps once per tick through rise, hold, fall, hold.
module led_breather
    import led_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int STEP       = 8,
    parameter int HOLD_TICKS = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic tick,
    output logic LED1,
    output logic LED2,
    output logic LED3,
    output logic LED4,
    output logic LED5
);

    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PWM_BITS-1:0] STP = PWM_BITS'(STEP);
    localparam logic [PWM_BITS-1:0] TH1 = PWM_BITS'(bar_thresh(PWM_BITS, 1));
    localparam logic [PWM_BITS-1:0] TH2 = PWM_BITS'(bar_thresh(PWM_BITS, 2));
    localparam logic [PWM_BITS-1:0] TH3 = PWM_BITS'(bar_thresh(PWM_BITS, 3));
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    state_t              state;
    logic [PWM_BITS-1:0] level;
    logic [HW-1:0]       hold_cnt;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS-1:0] lvl_up;
    logic [PWM_BITS-1:0] lvl_dn;
    logic                clr;

    assign clr = ~enable;

    // Saturating step arithmetic, one bit wider on the way up
    always_comb begin
        up_sum = {1'b0, level} + (PWM_BITS + 1)'(STEP);
        lvl_up = up_sum[PWM_BITS] ? MAX : up_sum[PWM_BITS-1:0];
        lvl_dn = (level > STP) ? (level - STP) : '0;
    end

    // Breathing sequencer; disable wins over tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            level    <= '0;
            hold_cnt <= '0;
        end else if (!enable) begin
            state    <= ST_IDLE;
            level    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state <= ST_RISE;
                end
                ST_RISE: begin
                    if (tick) begin
                        level <= lvl_up;
                        if (lvl_up == MAX) begin
                            state    <= ST_HOLD_HI;
                            hold_cnt <= '0;
                        end
                    end
                end
                ST_HOLD_HI: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST)
                            state <= ST_FALL;
                        else
                            hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                ST_FALL: begin
                    if (tick) begin
                        level <= lvl_dn;
                        if (lvl_dn == '0) begin
                            state    <= ST_HOLD_LO;
                            hold_cnt <= '0;
                        end
                    end
                end
                ST_HOLD_LO: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST)
                            state <= ST_RISE;
                        else
                            hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered bar graph driven from level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            LED1 <= 1'b0;
            LED2 <= 1'b0;
            LED3 <= 1'b0;
            LED4 <= 1'b0;
        end else begin
            LED1 <= level >= TH1;
            LED2 <= level >= TH2;
            LED3 <= level >= TH3;
            LED4 <= level == MAX;
        end
    end

    pwm_gen #(
        .BITS (PWM_BITS)
    ) u_pwm (
        .clk   (clk),
        .reset (reset),
        .clear (clr),
        .level (level),
        .led   (LED5)
    );

endmodule

// File: doc/led_breather.md
# led_breather

Downstream LED driver for the board's five LEDs. It consumes a one-cycle `tick` strobe from the free-running clock divider and produces a "breathing" display. LED5 is PWM-faded up and down, and LED1–LED4 show the current brightness as a 4-segment bar graph. It replaces the static LED assignments in the top level with a timed, state-driven pattern.

## Interface
- `PWM_BITS`, default 8: width of the brightness level and of the PWM counter; MAX = 2^PWM_BITS−1.
- `STEP`, default 8: level increment/decrement applied per `tick` while fading; 1 ≤ STEP ≤ MAX.
- `HOLD_TICKS`, default 16: number of ticks spent at full and at zero brightness; ≥ 1.
- `clk` in 1: single system clock; all state is updated on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `enable` in 1: run the pattern when high; force everything dark when low.
- `tick` in 1: one-`clk` strobe from the upstream divider; pulses longer than one cycle count once per cycle.
- `LED1`–`LED4` out 1 each: bar-graph segments.
- `LED5` out 1: PWM brightness output.

## Operation
- FSM states: IDLE, RISE, HOLD_HI, FALL, HOLD_LO.
- Registers:
  - `level` (PWM_BITS): brightness target.
  - `duty` (PWM_BITS): shadow of `level` actually used by the PWM.
  - `pwm_cnt` (PWM_BITS): free-running PWM counter.
  - `hold_cnt`: wide enough for HOLD_TICKS.
- Reset values: state = IDLE; `level`, `duty`, `pwm_cnt`, `hold_cnt` = 0; all LEDs = 0.
- IDLE: if `enable` = 1, go to RISE on the next cycle (no tick needed).
- RISE: on each `tick`, `level` ← min(`level`+STEP, MAX) using saturating arithmetic computed one bit wider. When the new value equals MAX, go to HOLD_HI with `hold_cnt` = 0.
- HOLD_HI: on each `tick`, `hold_cnt`++. When it reaches HOLD_TICKS−1 on a tick, go to FALL.
- FALL: on each `tick`, `level` ← max(`level`−STEP, 0), saturating. When the new value equals 0, go to HOLD_LO with `hold_cnt` = 0.
- HOLD_LO: same as HOLD_HI, then go to RISE.
- `enable` = 0 in any state, with priority over `tick`: next cycle state = IDLE and `level` = `duty` = 0. `pwm_cnt` keeps running.
- PWM:
  - `pwm_cnt` increments every cycle and wraps MAX→0.
  - `duty` ← `level` only in the cycle where `pwm_cnt` == MAX, so a PWM period is never glitched mid-cycle. The exception is the `enable` = 0 clear, which takes effect immediately.
- LED5 = (`duty` == MAX) | (`pwm_cnt` < `duty`):
  - `duty` 0 → constantly low.
  - `duty` MAX → constantly high.
  - otherwise duty cycle is `duty`/2^PWM_BITS.
- Bar graph, using the top two bits of `level` (not `duty`):
  - LED1 = `level` ≥ 1.
  - LED2 = `level` ≥ 2^(PWM_BITS−2).
  - LED3 = `level` ≥ 2^(PWM_BITS−1).
  - LED4 = `level` == MAX.
- All outputs are registered.

## Timing
- `tick` sampled at edge N changes `level` at edge N; the bar-graph LEDs reflect it after edge N+1.
- LED5 reflects a new `level` at most 2^PWM_BITS+1 cycles later, at the first PWM period boundary.
- `enable` falling at edge N: all LEDs are 0 after edge N+1.
- `enable` rising: IDLE→RISE takes 1 cycle; the first level step comes on the first `tick` after that.
- Full breathing period = 2·ceil(MAX/STEP) + 2·HOLD_TICKS ticks.
- Asynchronous `reset` mid-fade returns every register to its reset value without waiting for a clock edge. Operation resumes from IDLE on the first edge after `reset` is released.
- `tick` in the same cycle as a state transition is consumed by the transition only; there is no double step.

## Structure
- Shared package `led_pkg`:
  - FSM state enum (`ST_IDLE`…`ST_HOLD_LO`).
  - Bar-graph threshold function of PWM_BITS.
- One natural sub-module: `pwm_gen`, holding `pwm_cnt`, the `duty` shadow register and the LED5 compare. Its inputs are `level` and a synchronous clear.
- The FSM, `level` arithmetic and bar graph stay in `led_breather`.

## Test plan
Bench uses PWM_BITS=4, STEP=4, HOLD_TICKS=2 and a `tick` every 20 cycles.
- Reset/idle: `reset` high, then low with `enable` = 0 for 100 cycles → all LEDs stay 0 and the state stays IDLE.
- One full breath with `enable` = 1:
  - `level` follows 4, 8, 12, 15 (saturated), holds for 2 ticks, then 11, 7, 3, 0, holds for 2 ticks, then restarts at 4.
  - Period is 12 ticks.
- PWM duty: force `level` = 8 → LED5 is high 8 of every 16 cycles. At `level` 15 LED5 is constantly high; at `level` 0 it is constantly low.
- Glitch-free update: change `level` mid-period (`pwm_cnt` = 5) → LED5 waveform for the current period is unchanged, and the new duty starts when `pwm_cnt` wraps to 0.
- `enable` drop during RISE with `tick` asserted in the same cycle → one cycle later all LEDs are 0 and `level` = 0; no step is applied.
- Asynchronous `reset` asserted between clock edges during HOLD_HI → outputs are 0 before the next edge, and after release the pattern restarts from `level` 0.
